cam_capture_ctrl: RTL

- Frame-capture sequencer for the OV7670 path.
- Arms on a start request and synchronises to the camera frame (VSYNC/HREF).
- Packs RGB565 byte pairs into RGB332 pixels and drives write-enable/address into the frame-buffer RAM, one frame per request.
- Replaces free-running pixel counting with a bounded, handshaked controller: start/busy/done/overflow.

---
 rtl/cam_pkg.sv | 22 ++
 rtl/cam_byte_packer.sv | 39 +++
 rtl/cam_capture_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture and display paths:
// FSM state encoding, default frame geometry, RGB565 -> RGB332 pixel reduction.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } cam_state_t;

  localparam int CAM_H_RES  = 160;
  localparam int CAM_V_RES  = 120;
  localparam int CAM_ADDR_W = 15;

  // Keeps the top 3 red bits, the top 3 green bits and the top 2 blue bits.
  // The green bits sit in the low bits of hi; the blue bits sit in lo[4:0].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Pairs camera bytes (RGB565, high byte first) into RGB332 pixels.
// A pixel strobe and its data appear one pclk after the second byte is sampled.
module cam_byte_packer
  import cam_pkg::*;
(
  input  logic       pclk,
  input  logic       rst,
  input  logic       en_p0,
  input  logic       clr_p0,
  input  logic [7:0] d_p0,
  output logic       vld_p1,
  output logic [7:0] pix_p1
);

  logic       phase_p0;
  logic [7:0] b1_p0;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      phase_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      pix_p1   <= '0;
    end else begin
      vld_p1 <= en_p0 & phase_p0;
      if (clr_p0)
        phase_p0 <= 1'b0;
      else if (en_p0)
        phase_p0 <= ~phase_p0;
      if (en_p0 && phase_p0)
        pix_p1 <= rgb565_to_rgb332(b1_p0, d_p0);
    end
  end

  always_ff @(posedge pclk) begin
    if (en_p0 && !phase_p0)
      b1_p0 <= d_p0;
  end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Single-frame capture sequencer: start/busy/done handshake, frame sync and frame-buffer addressing.
// Define CAM_CAPTURE_CONTINUOUS_EN to re-arm automatically after every frame.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_RES  = CAM_H_RES,
  parameter int V_RES  = CAM_V_RES,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata
);

  localparam int CW = $clog2(H_RES + 1);
  localparam int RW = $clog2(V_RES + 1);
  localparam logic [CW-1:0]     H_LIM  = CW'(H_RES);
  localparam logic [RW-1:0]     V_LIM  = RW'(V_RES);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_RES * V_RES - 1);

  cam_state_t state, state_nxt;

  logic          vsync_p1, href_p1;
  logic          vs_rise, vs_fall, hr_fall;
  logic          arm, cap_en, pack_clr, vld_p1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          line_pix;

  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    return (c < H_LIM) ? c + CW'(1) : c;
  endfunction

  function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
    return (r < V_LIM) ? r + RW'(1) : r;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == A_LAST) ? a : a + ADDR_W'(1);
  endfunction

  assign vs_rise = vsync & ~vsync_p1;
  assign vs_fall = ~vsync & vsync_p1;
  assign hr_fall = ~href & href_p1;

  // Bytes are taken only inside the frame; the vsync-rise cycle drops a pending half pixel.
  assign cap_en   = (state == CAPTURE) & href & ~vs_rise;
  assign pack_clr = (state != CAPTURE) | hr_fall | vs_rise;

  cam_byte_packer u_packer (
    .pclk   (pclk),
    .rst    (rst),
    .en_p0  (cap_en),
    .clr_p0 (pack_clr),
    .d_p0   (d),
    .vld_p1 (vld_p1),
    .pix_p1 (wdata)
  );

  // Out-of-window pixels are dropped here and reported through overflow.
  assign we = vld_p1 && (col < H_LIM) && (row < V_LIM);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    arm       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_FRAME;
          arm       = 1'b1;
        end
      end
      WAIT_FRAME: begin
        busy = 1'b1;
        if (vs_fall)
          state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (vs_rise)
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
`ifdef CAM_CAPTURE_CONTINUOUS_EN
        state_nxt = WAIT_FRAME;
        arm       = 1'b1;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: sync-edge history, line/frame counters and write address.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
      overflow <= 1'b0;
      waddr    <= '0;
      col      <= '0;
      row      <= '0;
      line_pix <= 1'b0;
    end else begin
      vsync_p1 <= vsync;
      href_p1  <= href;
      if (arm) begin
        overflow <= 1'b0;
        waddr    <= '0;
        col      <= '0;
        row      <= '0;
        line_pix <= 1'b0;
      end else begin
        if (vld_p1) begin
          if (we)
            waddr <= addr_inc(waddr);
          else
            overflow <= 1'b1;
          col      <= col_inc(col);
          line_pix <= 1'b1;
        end
        // The last pixel of a line may still be in flight on the href fall cycle.
        if (state == CAPTURE && hr_fall) begin
          col      <= '0;
          line_pix <= 1'b0;
          if (line_pix || vld_p1)
            row <= row_inc(row);
        end
      end
    end
  end

endmodule
